// File: rtl/uart_rx_deser_pkg.sv
// Shared types and constants for the UART receive deserialiser.
// The length helper clamps a requested frame length into the legal range.
package uart_rx_pkg;

    localparam int DESER_LEN_MIN = 5;
    localparam int DESER_DATA_W  = 8;
    localparam int DESER_LEN_W   = 4;

    typedef enum logic [1:0] {
        DESER_IDLE,
        DESER_SHIFT,
        DESER_DONE
    } deser_state_t;

    function automatic int deser_eff_len(input int req_len, input int max_len);
        if (req_len < DESER_LEN_MIN) return DESER_LEN_MIN;
        else if (req_len > max_len) return max_len;
        return req_len;
    endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// Bus between the RX FSM / sampler (master) and the deserialiser (slave).
// par_bit exists only when UART_DESER_PARITY_EN is defined.
interface uart_rx_deser_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = DESER_DATA_W,
    parameter int LEN_W  = DESER_LEN_W
);
    logic              deser_en;
    logic              frame_start;
    logic              sample_vld;
    logic              sampled_bit;
    logic              lsb_first;
    logic [LEN_W-1:0]  data_len;
    logic [DATA_W-1:0] p_data;
    logic              data_vld;
    logic              busy;
    logic [LEN_W-1:0]  bit_cnt;
`ifdef UART_DESER_PARITY_EN
    logic              par_bit;

    modport master (
        output deser_en, frame_start, sample_vld, sampled_bit, lsb_first, data_len,
        input  p_data, data_vld, busy, bit_cnt, par_bit
    );
    modport slave (
        input  deser_en, frame_start, sample_vld, sampled_bit, lsb_first, data_len,
        output p_data, data_vld, busy, bit_cnt, par_bit
    );
`else
    modport master (
        output deser_en, frame_start, sample_vld, sampled_bit, lsb_first, data_len,
        input  p_data, data_vld, busy, bit_cnt
    );
    modport slave (
        input  deser_en, frame_start, sample_vld, sampled_bit, lsb_first, data_len,
        output p_data, data_vld, busy, bit_cnt
    );
`endif
endinterface

// File: rtl/uart_rx_deser_bit_cnt.sv
// Data-bit counter for the deserialiser: synchronous clear beats increment,
// and last flags the final bit position of the current frame (cnt == len-1).
module deser_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int LEN_W = DESER_LEN_W
) (
    input  logic             clk_RX,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign last = (cnt == len - 1'b1);

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: assembles voted serial bits into a parallel word.
// Optional parity output is enabled by defining UART_DESER_PARITY_EN.
module uart_rx_deser
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = DESER_DATA_W,
    parameter int LEN_W  = DESER_LEN_W
) (
    input  logic           clk_RX,
    input  logic           rst,
    uart_rx_deser_if.slave bus
);

    deser_state_t      state, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next, p_data_q;
    logic              data_vld_q, lsb_q;
    logic [LEN_W-1:0]  len_q, len_eff, wr_idx, cnt;
    logic              cnt_last, start, take, finish, cnt_clr;

    assign len_eff = LEN_W'(deser_eff_len(int'(bus.data_len), DATA_W));
    assign wr_idx  = lsb_q ? cnt : (len_q - 1'b1 - cnt);

    // The counter also clears on abort and while in DONE, so it reads 0 in IDLE.
    assign cnt_clr = start || !bus.deser_en || (state == DESER_DONE);

    deser_bit_cnt #(.LEN_W(LEN_W)) u_bit_cnt (
        .clk_RX (clk_RX),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (take),
        .len    (len_q),
        .cnt    (cnt),
        .last   (cnt_last)
    );

    always_comb begin
        shift_next = shift_reg;
        for (int i = 0; i < DATA_W; i++) begin
            if (LEN_W'(i) == wr_idx) shift_next[i] = bus.sampled_bit;
        end
    end

    // A frame_start arriving mid-frame restarts the frame and takes priority over a sample.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        take       = 1'b0;
        finish     = 1'b0;
        if (!bus.deser_en) begin
            state_next = DESER_IDLE;
        end else begin
            unique case (state)
                DESER_IDLE: begin
                    if (bus.frame_start) begin
                        start      = 1'b1;
                        state_next = DESER_SHIFT;
                    end
                end
                DESER_SHIFT: begin
                    if (bus.frame_start) begin
                        start = 1'b1;
                    end else if (bus.sample_vld) begin
                        take = 1'b1;
                        if (cnt_last) begin
                            finish     = 1'b1;
                            state_next = DESER_DONE;
                        end
                    end
                end
                DESER_DONE: state_next = DESER_IDLE;
                default:    state_next = DESER_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            state      <= DESER_IDLE;
            shift_reg  <= '0;
            p_data_q   <= '0;
            data_vld_q <= 1'b0;
            lsb_q      <= 1'b1;
            len_q      <= LEN_W'(DATA_W);
        end else begin
            state      <= state_next;
            data_vld_q <= finish;
            if (start) begin
                shift_reg <= '0;
                lsb_q     <= bus.lsb_first;
                len_q     <= len_eff;
            end else if (take) begin
                shift_reg <= shift_next;
            end
            if (finish) p_data_q <= shift_next;
        end
    end

`ifdef UART_DESER_PARITY_EN
    // Unused upper bits are cleared at frame start, so a full-width XOR is the len-bit parity.
    logic par_q;

    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst)
            par_q <= 1'b0;
        else if (finish)
            par_q <= ^shift_next;
    end

    assign bus.par_bit = par_q;
`endif

    assign bus.p_data   = p_data_q;
    assign bus.data_vld = data_vld_q;
    assign bus.busy     = (state == DESER_SHIFT);
    assign bus.bit_cnt  = cnt;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: directed frames from the requirements plus
// random frames compared against a word-level reference model.
module tb_uart_rx_deser;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic clk_RX = 1'b0;
    logic rst    = 1'b0;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [DATA_W-1:0] exp_pdata = '0;
    logic [DATA_W-1:0] held;

    uart_rx_deser_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    uart_rx_deser #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_RX (clk_RX),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 clk_RX = ~clk_RX;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the edge that sampled them.
    task automatic applyStimulus(input logic en, input logic fs, input logic sv, input logic sb);
        bus.deser_en    = en;
        bus.frame_start = fs;
        bus.sample_vld  = sv;
        bus.sampled_bit = sb;
        @(posedge clk_RX);
        #1;
        bus.frame_start = 1'b0;
        bus.sample_vld  = 1'b0;
    endtask

    function automatic int modelLen(input int req);
        if (req < 5) return 5;
        if (req > DATA_W) return DATA_W;
        return req;
    endfunction

    // serial[i] is the i-th bit on the line; its weight depends on bit order.
    function automatic logic [DATA_W-1:0] modelWord(input logic [15:0] serial, input int n,
                                                    input bit lsb);
        int acc = 0;
        for (int i = 0; i < n; i++) begin
            if (serial[i]) acc += (lsb ? (1 << i) : (1 << (n - 1 - i)));
        end
        return DATA_W'(acc);
    endfunction

    task automatic runFrame(input string tag, input logic [15:0] serial, input int len_req,
                            input bit lsb);
        int n = modelLen(len_req);
        bus.lsb_first = lsb;
        bus.data_len  = LEN_W'(len_req);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, "_cnt_start"}, 32'(bus.bit_cnt), 32'd0);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, serial[i]);
            if (i < n - 1) begin
                checkOutput({tag, "_cnt"}, 32'(bus.bit_cnt), 32'(i + 1));
                checkOutput({tag, "_vld_early"}, 32'(bus.data_vld), 32'd0);
                repeat ($urandom_range(0, 2)) begin
                    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
                    checkOutput({tag, "_vld_gap"}, 32'(bus.data_vld), 32'd0);
                end
            end
        end
        exp_pdata = modelWord(serial, n, lsb);
        checkOutput({tag, "_vld"}, 32'(bus.data_vld), 32'd1);
        checkOutput({tag, "_pdata"}, 32'(bus.p_data), 32'(exp_pdata));
`ifdef UART_DESER_PARITY_EN
        checkOutput({tag, "_par"}, 32'(bus.par_bit), 32'(^exp_pdata));
`endif
        checkOutput({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_vld_width"}, 32'(bus.data_vld), 32'd0);
        checkOutput({tag, "_cnt_idle"}, 32'(bus.bit_cnt), 32'd0);
        checkOutput({tag, "_pdata_hold"}, 32'(bus.p_data), 32'(exp_pdata));
    endtask

    initial begin
        bus.deser_en    = 1'b0;
        bus.frame_start = 1'b0;
        bus.sample_vld  = 1'b0;
        bus.sampled_bit = 1'b0;
        bus.lsb_first   = 1'b1;
        bus.data_len    = LEN_W'(8);
        repeat (3) @(posedge clk_RX);
        #1;
        checkOutput("rst_pdata", 32'(bus.p_data), 32'd0);
        checkOutput("rst_vld", 32'(bus.data_vld), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_cnt", 32'(bus.bit_cnt), 32'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] directed frames");
        runFrame("lsb8", 16'b0100_1101, 8, 1'b1);
        checkOutput("lsb8_literal", 32'(bus.p_data), 32'h4D);
        runFrame("msb8", 16'b0100_1101, 8, 1'b0);
        checkOutput("msb8_literal", 32'(bus.p_data), 32'hB2);
        runFrame("len5", 16'b1_1011, 5, 1'b1);
        checkOutput("len5_literal", 32'(bus.p_data), 32'h1B);
        runFrame("len3", 16'b1_1011, 3, 1'b1);
        checkOutput("len3_literal", 32'(bus.p_data), 32'h1B);
        runFrame("len12", 16'($urandom), 12, 1'b1);

        // frame_start with deser_en low must not open a frame
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("en_wins_busy", 32'(bus.busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("en_wins_cnt", 32'(bus.bit_cnt), 32'd0);

        $display("[TB] abort and restart");
        held = exp_pdata;
        bus.data_len = LEN_W'(8);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_cnt", 32'(bus.bit_cnt), 32'd0);
        checkOutput("abort_vld", 32'(bus.data_vld), 32'd0);
        checkOutput("abort_pdata", 32'(bus.p_data), 32'(held));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("abort_vld_after", 32'(bus.data_vld), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
            checkOutput("partial_vld", 32'(bus.data_vld), 32'd0);
        end
        runFrame("restart", 16'($urandom), 8, 1'b1);

        $display("[TB] reset mid-frame");
        bus.data_len = LEN_W'(8);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b0;
        exp_pdata = '0;
        #1;
        checkOutput("midrst_pdata", 32'(bus.p_data), 32'd0);
        checkOutput("midrst_vld", 32'(bus.data_vld), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_cnt", 32'(bus.bit_cnt), 32'd0);
        @(negedge clk_RX);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
            checkOutput("stray_vld", 32'(bus.data_vld), 32'd0);
            checkOutput("stray_busy", 32'(bus.busy), 32'd0);
            checkOutput("stray_cnt", 32'(bus.bit_cnt), 32'd0);
            checkOutput("stray_pdata", 32'(bus.p_data), 32'd0);
        end
        runFrame("post_rst", 16'($urandom), 8, 1'b1);

        $display("[TB] random frames");
        for (int k = 0; k < 24; k++) begin
            runFrame("rand", 16'($urandom), int'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter DATA_W, default 8, maximum frame data width in bits (legal 5..9).
REQ-002 Parameter LEN_W, default 4, width of the runtime length input.
REQ-003 clk_RX  input  1  receive clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 deser_en  input  1  enable from RX FSM; low aborts any frame in progress.
REQ-006 frame_start  input  1  single-cycle pulse: start bit accepted, open a new data frame.
REQ-007 sample_vld  input  1  single-cycle strobe: sampled_bit holds the voted value of the current data bit.
REQ-008 sampled_bit  input  1  voted serial bit.
REQ-009 lsb_first  input  1  bit order: 1 = LSB first (UART standard), 0 = MSB first.
REQ-010 data_len  input  LEN_W  number of data bits per frame.
REQ-011 p_data  output  DATA_W  last completed parallel word; unused upper bits zero.
REQ-012 data_vld  output  1  one-cycle pulse when p_data is updated.
REQ-013 busy  output  1  high while a frame is being assembled.
REQ-014 bit_cnt  output  LEN_W  number of data bits received in the current frame.

Function
REQ-015 Three states: IDLE, SHIFT and DONE; the block starts in IDLE.
REQ-016 IDLE to SHIFT: on frame_start with deser_en=1; clears the shift register and bit_cnt; latches lsb_first and the effective length.
REQ-017 Effective length: data_len clamped to 5 if below 5; clamped to DATA_W if above DATA_W.
REQ-018 In SHIFT, each sample_vld writes sampled_bit to index bit_cnt (LSB-first) or index len-1-bit_cnt (MSB-first), then increments bit_cnt.
REQ-019 sample_vld with bit_cnt = len-1: the shift register value, including that final bit, is written to p_data on the same edge; data_vld is high the next cycle; state goes to DONE.
REQ-020 DONE to IDLE unconditionally after one cycle; data_vld is exactly one cycle wide.
REQ-021 sample_vld in IDLE or DONE: ignored.
REQ-022 frame_start in SHIFT: restart, i.e. clear and relatch as in REQ-016; the partial word is discarded and data_vld is not asserted.
REQ-023 deser_en low in any state: go to IDLE next edge; p_data unchanged; data_vld low.
REQ-024 frame_start and deser_en low in the same cycle: deser_en wins.
REQ-025 busy = (state == SHIFT); bit_cnt reads 0 in IDLE.
REQ-026 p_data holds its value between frames; only REQ-019 writes it.
REQ-027 Latency: data_vld is asserted 1 cycle after the final sample_vld.

Reset
REQ-028 rst low: state IDLE; p_data, shift register, bit_cnt, data_vld, busy and par_bit all 0; latched settings set to LSB-first, length DATA_W.
REQ-029 rst low mid-frame: the frame is lost and no data_vld is produced after rst is released.

Configuration
REQ-030 Macro UART_DESER_PARITY_EN defined: adds output par_bit (1), the XOR of the len data bits of the completed word, updated on the same edge as p_data; reset value 0.
REQ-031 Macro undefined: par_bit port and its logic absent; all other behaviour identical.

Structure
REQ-032 Package uart_rx_pkg: deser state enum, DESER_LEN_MIN=5, default DATA_W and LEN_W constants.
REQ-033 One sub-module, deser_bit_cnt: clear, increment and terminal-count flag (bit_cnt == len-1), parametrised by LEN_W.

Verification
REQ-034 DATA_W=8, len=8, LSB-first, serial 1,0,1,1,0,0,1,0 -> p_data=8'h4D, one data_vld 1 cycle after the 8th strobe (par_bit=0 when enabled).
REQ-035 Same bits, lsb_first=0 -> p_data=8'hB2.
REQ-036 len=5, LSB-first, bits 1,1,0,1,1 -> p_data=8'h1B, bits [7:5]=0; len=3 clamps to 5 with the same result; len=12 clamps to 8.
REQ-037 Abort and restart: deser_en low after 4 bits -> no data_vld, prior p_data held; frame_start after 3 bits then 8 new bits -> only the new word appears, with one data_vld.
REQ-038 rst low after 6 bits, then released -> all outputs 0, state IDLE; 2 stray sample_vld pulses are ignored; the next full frame decodes correctly.
